instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end for the 8-bit micro-sequenced CPU core. It holds a small program store, maintains the program counter and prefetches instructions into a 2-entry queue. It presents one 8-bit instruction per cycle to the core's instruction input through a valid/ready handshake. It also supports program loading, jump redirection and halting on the HALT opcode.

## Interface
- ADDR_W, 6: program-store address width; store depth = 2**ADDR_W words of 8 bits.
- HALT_OP, 8'hFF: opcode that stops further fetching.
- clk  input  1  single system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears all state except program-store contents.
- prog_we  input  1  program-store write strobe; honoured only in IDLE or HALT.
- prog_addr  input  ADDR_W  program-store write address.
- prog_data  input  8  program-store write data.
- run  input  1  level; start/continue fetching.
- jump_en  input  1  one-cycle redirect request.
- jump_addr  input  ADDR_W  redirect target.
- instr_ready  input  1  core accepts instr_out this cycle.
- instr_out  output  8  instruction at queue head; 8'h00 when queue empty.
- instr_valid  output  1  queue non-empty.
- pc_out  output  ADDR_W  address of the instruction at queue head; 0 when empty.
- halted  output  1  state HALT and queue empty.

## Operation
- FSM states: IDLE (reset), FETCH, HALT.
- IDLE -> FETCH when run=1. FETCH -> IDLE when run=0; the in-flight read still completes and enqueues. FETCH -> HALT when a word equal to HALT_OP is written into the queue. HALT -> FETCH only on jump_en. HALT -> IDLE only on reset.
- Program store: synchronous read with 1-cycle registered output. No reset of contents. prog_we in FETCH is ignored.
- Read issue in FETCH: allowed when (count + pending - pop) < 2, where pop = instr_valid & instr_ready. On issue: read addr = pc; pc <= pc + 1, wrapping from 2**ADDR_W-1 to 0; pending <= 1.
- No read is issued in the cycle where the data returning from the previous read equals HALT_OP. That data is still enqueued and delivered.
- Queue: 2 entries, each holding {instr, addr}. Simultaneous push and pop is legal at any count. Overflow cannot occur because of the issue rule.
- Handshake: a transfer occurs on a rising edge when instr_valid=1 and instr_ready=1. instr_out/pc_out remain stable while valid=1 and ready=0.
- jump_en takes priority over all other events in the same cycle:
  - Queue is flushed, pending read is discarded, and pc <= jump_addr.
  - A pop in that cycle is not counted as a transfer.
  - State becomes FETCH if it was FETCH or HALT. If state was IDLE, only pc is loaded and state stays IDLE.
- The pc width rule is modulo 2**ADDR_W. No wide arithmetic is used.

## Timing
- Reset values: state=IDLE, pc=0, pending=0, count=0, instr_out=0, instr_valid=0, pc_out=0, halted=0.
- Latency: with run=1 sampled at edge E0 in IDLE, the first read is issued in the cycle after E0 and instr_valid=1 after edge E0+2.
- Throughput: with instr_ready held high, one instruction per cycle is sustained from the first valid onward.
- Jump: instr_valid=0 the cycle after jump_en. The first instruction from the new target is valid 2 edges after the jump edge.
- Reset asserted mid-operation clears the queue and pending read on that edge. Outputs return to reset values the next cycle.

## Test plan
- Load 0x10,0x21,0x32,0xFF at 0..3, run=1, ready=1:
  - Required: instr_out sequence 10,21,32,FF on consecutive cycles, valid first 2 edges after run.
  - Required: pc_out 0,1,2,3, then halted=1 and no further valid.
- Same program with ready toggled 1,0,0,1,...:
  - Required: no instruction lost or duplicated; outputs stable while stalled.
  - Required: queue never exceeds 2 entries.
- jump_en with jump_addr=0x20 while 2 entries queued and a read pending:
  - Required: valid=0 next cycle; next delivered instr is mem[0x20] with pc_out=0x20; old entries never appear.
- Program 0x01 at 63 and 0x02 at 0, start via jump to 63:
  - Required: delivers 01 then 02; pc wraps 63->0.
- In HALT, prog_we writes 0x55 at 5, then jump_en to 5:
  - Required: 0x55 delivered with pc_out=5; prog_we during FETCH leaves memory unchanged.
- Assert reset while valid=1 and pending=1:
  - Required: next cycle instr_valid=0, pc_out=0, halted=0, state IDLE; program contents retained, verified by re-run.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Program store, PC and 2-entry prefetch queue feeding the core
//            through a valid/ready handshake, with jump redirect and HALT stop.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int         ADDR_W  = 6,
    parameter logic [7:0] HALT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              run,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              instr_ready,
    output logic [7:0]        instr_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    localparam int EW = 8 + ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        rd_data_q;
    logic              pending_q;
    logic [1:0]        count_q, count_d;
    logic [EW-1:0]     e0_q, e0_d, e1_q, e1_d;
    logic [7:0]        instr_q;
    logic              valid_q;
    logic [ADDR_W-1:0] pcout_q;
    logic              halted_q;

    logic [7:0]        mem [2**ADDR_W];

    logic              w_pop, w_push, w_ret_halt, w_issue;
    logic [2:0]        w_occ;
    logic [EW-1:0]     w_new;

    // A jump cancels both the transfer and the returning read of its cycle.
    assign w_pop      = valid_q & instr_ready & ~jump_en;
    assign w_push     = pending_q & ~jump_en;
    assign w_ret_halt = pending_q && (rd_data_q == HALT_OP);
    assign w_occ      = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, w_pop};
    assign w_issue    = (state_q == S_FETCH) && run && !jump_en && !w_ret_halt
                        && (w_occ < 3'd2);
    assign w_new      = {rd_data_q, rd_addr_q};

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10: begin
                if (count_q == 2'd0) e0_d = w_new;
                else                 e1_d = w_new;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    e0_d = w_new;
                end else begin
                    e0_d = e1_q;
                    e1_d = w_new;
                end
            end
            default: ;
        endcase
        if (jump_en) count_d = 2'd0;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (jump_en) begin
            pc_d = jump_addr;
            if (state_q != S_IDLE) state_d = S_FETCH;
        end else begin
            if (w_issue) pc_d = pc_q + 1'b1;
            case (state_q)
                S_IDLE:  if (run) state_d = S_FETCH;
                S_FETCH: begin
                    if (w_push && (rd_data_q == HALT_OP)) state_d = S_HALT;
                    else if (!run)                        state_d = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && (state_q != S_FETCH)) mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            pending_q <= 1'b0;
            count_q   <= 2'd0;
            e0_q      <= '0;
            e1_q      <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            pcout_q   <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= w_issue;
            if (w_issue) begin
                rd_addr_q <= pc_q;
                rd_data_q <= mem[pc_q];
            end
            count_q   <= count_d;
            e0_q      <= e0_d;
            e1_q      <= e1_d;
            // Outputs are registered from next-state so they track the queue head.
            valid_q   <= (count_d != 2'd0);
            instr_q   <= (count_d != 2'd0) ? e0_d[EW-1 -: 8] : 8'h00;
            pcout_q   <= (count_d != 2'd0) ? e0_d[ADDR_W-1:0] : '0;
            halted_q  <= (state_d == S_HALT) && (count_d == 2'd0);
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pcout_q;
    assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Scoreboard bench for instr_fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset, prog_we, run, jump_en, instr_ready;
    logic [ADDR_W-1:0] prog_addr, jump_addr, pc_out;
    logic [7:0]        prog_data, instr_out;
    logic              instr_valid, halted;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .HALT_OP(8'hFF)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .run         (run),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .halted      (halted)
    );

    logic [7:0]  model_mem [64];
    logic [13:0] sb [$];
    logic [13:0] mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        stall_v  = 1'b0;
    logic [7:0]  stall_instr;
    logic [5:0]  stall_pc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [5:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        model_mem[a] = d;
        step();
        prog_we = 1'b0;
    endtask

    // Expected delivery: from start onward, wrapping, up to and including HALT.
    task automatic push_prog(input logic [5:0] start);
        logic [5:0] a;
        a = start;
        for (int k = 0; k < 64; k++) begin
            sb.push_back({model_mem[a], a});
            if (model_mem[a] == 8'hFF) break;
            a = a + 6'd1;
        end
    endtask

    task automatic kick(input string tag, input bit is_jump, input logic [5:0] addr,
                        input bit fetch_wr);
        int lat;
        if (is_jump) begin
            jump_addr = addr;
            jump_en   = 1'b1;
        end else begin
            run = 1'b1;
        end
        step();
        jump_en = 1'b0;
        if (fetch_wr) begin
            prog_we   = 1'b1;
            prog_addr = 6'd6;
            prog_data = 8'h77;
        end
        lat = 1;
        while (!instr_valid && lat < 16) begin
            step();
            prog_we = 1'b0;
            lat++;
        end
        prog_we = 1'b0;
        check_eq({tag, "_latency"}, lat, 3);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 64) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, sb.size(), 0);
        step();
        step();
        check_eq({tag, "_halted"}, halted, 1);
        check_eq({tag, "_valid_off"}, instr_valid, 0);
    endtask

    always @(negedge clk) begin
        if (reset || jump_en) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                check_eq("stall_instr", instr_out, stall_instr);
                check_eq("stall_pc", pc_out, stall_pc);
            end
            if (instr_valid) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_valid", instr_valid, 0);
                end else if (instr_ready) begin
                    mon_e = sb.pop_front();
                    check_eq("instr", instr_out, mon_e[13:6]);
                    check_eq("pc", pc_out, mon_e[5:0]);
                end
            end
            stall_v     = instr_valid && !instr_ready;
            stall_instr = instr_out;
            stall_pc    = pc_out;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; prog_we = 1'b0; run = 1'b0; jump_en = 1'b0; instr_ready = 1'b0;
        prog_addr = '0; prog_data = '0; jump_addr = '0;
        step();
        step();
        check_eq("rst_valid", instr_valid, 0);
        check_eq("rst_instr", instr_out, 0);
        check_eq("rst_pc", pc_out, 0);
        check_eq("rst_halted", halted, 0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) prog_write(6'(i), 8'h80 | 8'(i));
        prog_write(6'd0, 8'h10);
        prog_write(6'd1, 8'h21);
        prog_write(6'd2, 8'h32);
        prog_write(6'd3, 8'hFF);
        prog_write(6'h23, 8'hFF);

        // Straight run, ready held high.
        instr_ready = 1'b1;
        push_prog(6'd0);
        kick("run", 1'b0, 6'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check_eq("stream_valid", instr_valid, 1);
            step();
        end
        drain("run");

        // Same program with a 1,0,0 ready pattern.
        instr_ready = 1'b0;
        push_prog(6'd0);
        kick("toggle", 1'b1, 6'd0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            instr_ready = (k % 3 == 0);
            step();
        end
        instr_ready = 1'b1;
        drain("toggle");

        // Fill the queue, then redirect to 0x20.
        instr_ready = 1'b0;
        push_prog(6'd8);
        kick("prefill", 1'b1, 6'd8, 1'b0);
        step();
        step();
        step();
        sb.delete();
        push_prog(6'h20);
        kick("jump", 1'b1, 6'h20, 1'b0);
        instr_ready = 1'b1;
        drain("jump");

        // PC wrap 63 -> 0.
        prog_write(6'd63, 8'h01);
        prog_write(6'd0, 8'h02);
        prog_write(6'd1, 8'hFF);
        push_prog(6'd63);
        kick("wrap", 1'b1, 6'd63, 1'b0);
        drain("wrap");

        // Load in HALT is honoured; a write while fetching is ignored.
        prog_write(6'd5, 8'h55);
        prog_write(6'd6, 8'hFF);
        instr_ready = 1'b0;
        push_prog(6'd5);
        kick("hload", 1'b1, 6'd5, 1'b1);
        instr_ready = 1'b1;
        drain("hload");

        // Reset with an entry queued and a read pending.
        instr_ready = 1'b0;
        push_prog(6'h20);
        kick("prereset", 1'b1, 6'h20, 1'b0);
        reset = 1'b1;
        run   = 1'b0;
        sb.delete();
        step();
        check_eq("mid_rst_valid", instr_valid, 0);
        check_eq("mid_rst_pc", pc_out, 0);
        check_eq("mid_rst_halted", halted, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("idle_valid", instr_valid, 0);
        end
        push_prog(6'd0);
        kick("rerun", 1'b0, 6'd0, 1'b0);
        instr_ready = 1'b1;
        drain("rerun");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
